// File: rtl/alu_seq.sv
// Handshaked W-bit ALU: single-cycle arithmetic/logic/shift ops plus an
// iterative shift-add unsigned multiply, with registered result and Z/N/V/C.
module alu_seq #(
  parameter  int W   = 16,
  localparam int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] val_A,
  input  logic [W-1:0] val_B,
  input  logic [2:0]   alu_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] alu_out,
  output logic         Z,
  output logic         N,
  output logic         V,
  output logic         C
);

  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                         OP_NOTB = 3'b011, OP_LSL = 3'b100, OP_LSR = 3'b101,
                         OP_ASR = 3'b110, OP_MUL = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t           r_state;
  logic             r_valid;
  logic [W-1:0]     r_out;
  logic             r_z, r_n, r_v, r_c;
  logic [SHW-1:0]   r_cnt;
  logic [2*W-1:0]   r_acc;
  logic [2*W-1:0]   r_ma;
  logic [W-1:0]     r_mb;

  logic             w_accept;
  logic [SHW-1:0]   w_sh;
  logic [W:0]       w_sum, w_dif, w_shl, w_shr, w_asr;
  logic [W-1:0]     w_res;
  logic             w_v, w_c;

  assign in_ready = !reset && (r_state == S_IDLE) && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_sh     = val_B[SHW-1:0];

  // One extra bit on each shift captures the last bit shifted out (0 when sh=0)
  assign w_sum = {1'b0, val_A} + {1'b0, val_B};
  assign w_dif = {1'b0, val_A} + {1'b0, ~val_B} + (W+1)'(1);
  assign w_shl = {1'b0, val_A} << w_sh;
  assign w_shr = {val_A, 1'b0} >> w_sh;
  assign w_asr = $signed({val_A, 1'b0}) >>> w_sh;

  always_comb begin
    w_res = '0;
    w_v   = 1'b0;
    w_c   = 1'b0;
    case (alu_op)
      OP_ADD: begin
        w_res = w_sum[W-1:0];
        w_c   = w_sum[W];
        w_v   = (val_A[W-1] == val_B[W-1]) && (w_sum[W-1] != val_A[W-1]);
      end
      OP_SUB: begin
        w_res = w_dif[W-1:0];
        w_c   = w_dif[W];
        w_v   = (val_A[W-1] != val_B[W-1]) && (w_dif[W-1] != val_A[W-1]);
      end
      OP_AND:  w_res = val_A & val_B;
      OP_NOTB: w_res = ~val_B;
      OP_LSL: begin
        w_res = w_shl[W-1:0];
        w_c   = w_shl[W];
      end
      OP_LSR: begin
        w_res = w_shr[W:1];
        w_c   = w_shr[0];
      end
      OP_ASR: begin
        w_res = w_asr[W:1];
        w_c   = w_asr[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_out   <= '0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      r_v     <= 1'b0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_ma    <= '0;
      r_mb    <= '0;
    end else begin
      if (r_valid && out_ready) r_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          if (alu_op == OP_MUL) begin
            r_state <= S_MUL;
            r_ma    <= {{W{1'b0}}, val_A};
            r_mb    <= val_B;
            r_acc   <= '0;
            r_cnt   <= '0;
          end else begin
            r_valid <= 1'b1;
            r_out   <= w_res;
            r_z     <= (w_res == '0);
            r_n     <= w_res[W-1];
            r_v     <= w_v;
            r_c     <= w_c;
          end
        end
        S_MUL: begin
          // A<<cnt and B[cnt] kept as running shifts instead of indexed muxes
          if (r_mb[0]) r_acc <= r_acc + r_ma;
          r_ma  <= r_ma << 1;
          r_mb  <= r_mb >> 1;
          r_cnt <= r_cnt + SHW'(1);
          if (r_cnt == SHW'(W-1)) r_state <= S_DONE;
        end
        S_DONE: begin
          r_valid <= 1'b1;
          r_out   <= r_acc[W-1:0];
          r_z     <= (r_acc[W-1:0] == '0);
          r_n     <= r_acc[W-1];
          r_v     <= |r_acc[2*W-1:W];
          r_c     <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = r_valid;
  assign alu_out   = r_out;
  assign Z         = r_z;
  assign N         = r_n;
  assign V         = r_v;
  assign C         = r_c;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the datapath's 16-bit combinational ALU. Adds operand width W, shifts, an iterative unsigned multiply, a carry flag, and registered result/flags.
- Sits between the register-file operand latches and the writeback/status register.
- Accepts one operation at a time on a valid/ready input channel and returns result plus Z/N/V/C on a valid/ready output channel.

Parameters:
- W, 16, operand/result width; power of 2, at least 4.
- SHW, $clog2(W), derived shift-amount width; not overridden.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept an operation this cycle.
- val_A  in  W  operand A.
- val_B  in  W  operand B; shifts use B[SHW-1:0] as the shift amount.
- alu_op  in  3  000 ADD, 001 SUB, 010 AND, 011 NOTB, 100 LSL, 101 LSR, 110 ASR, 111 MUL.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result this cycle.
- alu_out  out  W  result.
- Z  out  1  zero flag.
- N  out  1  negative flag.
- V  out  1  overflow flag.
- C  out  1  carry flag.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous, active-high, and checked at each rising clk edge.
- Reset values: state=IDLE; out_valid=0; alu_out=0; Z=N=V=C=0; multiply counter=0.
- in_ready: in_ready = (state==IDLE) && (!out_valid || out_ready). It is combinational from state, out_valid and out_ready. It is 0 while reset is high.
- Accept: an operation is accepted at an edge where in_valid && in_ready. val_A, val_B and alu_op are sampled only at that edge.
- Single-cycle ops (all except MUL):
  - Result and flags are registered at the accept edge.
  - out_valid=1 after that edge, so latency is 1 cycle.
  - Back-to-back accepts at 1 per cycle are allowed while out_ready=1.
- FSM states: IDLE, MUL, DONE.
  - IDLE -> MUL on accepting MUL. Latch A, B; clear the 2W accumulator; cnt=0.
  - MUL: each cycle, if B[cnt]=1 then acc += A<<cnt; then cnt++. After the iteration with cnt==W-1, go to DONE.
  - DONE: register alu_out=acc[W-1:0] and flags, set out_valid=1, go to IDLE.
  - Net effect: out_valid rises W+1 edges after the accept edge (W=16 gives 17).
  - in_ready=0 in MUL and DONE.
- Output hold: while out_valid=1 && out_ready=0, alu_out, Z, N, V and C are held stable. out_valid drops at the edge where out_ready=1, unless a new accept at that same edge reloads it.
- Arithmetic, all W-bit with wrap-around:
  - ADD: result = A+B.
  - SUB: result = A+~B+1.
  - AND: result = A&B.
  - NOTB: result = ~B.
  - LSL / LSR: logical shifts by sh = B[SHW-1:0].
  - ASR: arithmetic shift, sign-filled.
  - MUL: low W bits of the unsigned A*B.
- Flags (registered together with the result):
  - Z = (result==0).
  - N = result[W-1].
  - V:
    - ADD: 1 if A and B have the same sign and the result sign differs.
    - SUB: 1 if A and B differ in sign and the result sign differs from A.
    - MUL: 1 if acc[2W-1:W] != 0.
    - All other ops: 0.
  - C:
    - ADD: carry out of bit W-1.
    - SUB: 1 if no borrow (A >= B unsigned).
    - LSL: last bit shifted out, A[W-sh]. LSR/ASR: last bit shifted out, A[sh-1].
    - Shifts with sh=0: C=0.
    - AND, NOTB, MUL: 0.
- Boundaries:
  - sh=0 leaves A unchanged.
  - Shift amounts use only the low SHW bits; for W=16, B=17 shifts by 1.
  - in_valid while in_ready=0 is ignored. The producer must hold its operands.
  - Reset mid-MUL aborts the operation: back to IDLE, out_valid=0, any pending result discarded.
  - Reset and accept at the same edge: reset wins, nothing is accepted.

Test Plan:
- W=16. Reset for 2 cycles -> out_valid=0, alu_out=0, ZNVC=0000, in_ready=1 after reset deasserts.
- ADD A=0x7FFF, B=0x0001, out_ready=1 -> 1 cycle later alu_out=0x8000, N=1, V=1, Z=0, C=0. SUB A=0x0005, B=0x0005 -> alu_out=0, Z=1, C=1, V=0.
- LSL A=0x8001, B=0x0011 -> sh=1, alu_out=0x0002, C=1. ASR A=0x8000, B=3 -> alu_out=0xF000, N=1, C=0. LSR with B=0 -> alu_out=A, C=0.
- MUL A=0x0100, B=0x0101 -> in_ready=0 for 17 cycles; out_valid rises exactly 17 edges after accept; alu_out=0x0100, V=1.
- Back-pressure: ADD result, out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, alu_out/flags stable. On out_ready=1, the held result drains and the next op is accepted in the same edge.
- Assert reset mid-MUL at cycle 8 -> out_valid stays 0, in_ready=1 the cycle after reset deasserts, no stale result ever appears.
